// File: rtl/status_collector_pkg.sv
`default_nettype none
// =============================================================================
// Module   : status_collector_pkg
// Desc     : Register map constants and channel address decode for the
//            multi-channel SHA-2 status collector.
// Revision : 1.0 - initial release
// =============================================================================
package status_collector_pkg;

    localparam logic [31:0] CTRL_OFS   = 32'h0000_0000;
    localparam logic [31:0] IRQ_OFS    = 32'h0000_0004;
    localparam logic [31:0] CH_BASE    = 32'h0000_0010;
    localparam logic [31:0] CH_STRIDE  = 32'h0000_0010;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0000;
    localparam logic [31:0] ERR_OFS    = 32'h0000_0004;
    localparam logic [31:0] COUNT_OFS  = 32'h0000_0008;

    localparam int ERR_BUF_BIT     = 0;
    localparam int ERR_PKT_BIT     = 1;
    localparam int ERR_CLR_BIT     = 31;
    localparam int CNT_CLR_ALL_BIT = 31;

    // Wide enough for the largest supported channel count (14).
    localparam int CH_IDX_W = 4;

    typedef logic [CH_IDX_W-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        REG_STATUS = 2'(STATUS_OFS >> 2),
        REG_ERR    = 2'(ERR_OFS >> 2),
        REG_COUNT  = 2'(COUNT_OFS >> 2),
        REG_RSVD   = 2'd3
    } ch_reg_e;

    typedef struct packed {
        logic    hit;
        ch_idx_t channel;
        ch_reg_e sel;
    } ch_dec_t;

    function automatic ch_dec_t ch_decode(input logic [31:0] addr, input logic [31:0] nch);
        logic [31:0] rel;
        logic [31:0] idx;
        ch_dec_t     d;
        rel       = addr - CH_BASE;
        idx       = rel / CH_STRIDE;
        d.hit     = (addr >= CH_BASE) && (idx < nch);
        d.channel = idx[CH_IDX_W-1:0];
        d.sel     = ch_reg_e'(2'((rel % CH_STRIDE) >> 2));
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/status_collector_channel.sv
`default_nettype none
// =============================================================================
// Module   : status_channel
// Desc     : Per-channel sticky W1C error flags, saturating packet counter and
//            one-cycle error-clear pulse generator.
// Revision : 1.0 - initial release
// =============================================================================
module status_channel #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_err_buffer,
    input  logic                   i_err_packet,
    input  logic                   i_pkt_done,
    input  logic                   i_err_wr,
    input  logic                   i_w1c_buf,
    input  logic                   i_w1c_pkt,
    input  logic                   i_clr_req,
    input  logic                   i_cnt_clr,
    output logic                   o_err_buf,
    output logic                   o_err_pkt,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_err_clear
);

    localparam logic [COUNT_WIDTH-1:0] c_cnt_max = '1;

    logic                   r_err_buf;
    logic                   r_err_pkt;
    logic                   r_err_clear;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_cnt_base;
    logic [COUNT_WIDTH-1:0] w_cnt_next;

    // Software clear lands first so a coincident packet leaves the count at 1.
    always_comb begin
        w_cnt_base = i_cnt_clr ? '0 : r_count;
        w_cnt_next = w_cnt_base;
        if (i_pkt_done && (w_cnt_base != c_cnt_max)) begin
            w_cnt_next = w_cnt_base + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err_buf   <= 1'b0;
            r_err_pkt   <= 1'b0;
            r_err_clear <= 1'b0;
            r_count     <= '0;
        end else begin
            r_err_buf   <= i_err_buffer | (r_err_buf & ~(i_err_wr & i_w1c_buf));
            r_err_pkt   <= i_err_packet | (r_err_pkt & ~(i_err_wr & i_w1c_pkt));
            r_err_clear <= i_err_wr & i_clr_req;
            r_count     <= w_cnt_next;
        end
    end

    assign o_err_buf   = r_err_buf;
    assign o_err_pkt   = r_err_pkt;
    assign o_count     = r_count;
    assign o_err_clear = r_err_clear;

endmodule
`default_nettype wire

// File: rtl/status_collector.sv
`default_nettype none
// =============================================================================
// Module   : status_collector
// Desc     : APB slave collecting status, sticky errors and packet counts from
//            CHANNELS SHA-2 pipeline channels, with a level interrupt.
// Revision : 1.0 - initial release
// =============================================================================
module status_collector
    import status_collector_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int ID_WIDTH    = 6,
    parameter int BUF_WIDTH   = 3,
    parameter int COUNT_WIDTH = 16,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_psel,
    input  logic                          i_penable,
    input  logic                          i_pwrite,
    input  logic [ADDR_WIDTH-1:0]         i_paddr,
    input  logic [31:0]                   i_pwdata,
    output logic [31:0]                   o_prdata,
    output logic                          o_pready,
    output logic                          o_pslverr,
    input  logic [CHANNELS*ID_WIDTH-1:0]  i_id,
    input  logic [CHANNELS*BUF_WIDTH-1:0] i_buffered,
    input  logic [CHANNELS-1:0]           i_err_buffer,
    input  logic [CHANNELS-1:0]           i_err_packet,
    input  logic [CHANNELS-1:0]           i_pkt_done,
    output logic [CHANNELS-1:0]           o_err_clear,
    output logic                          o_irq
);

    logic [31:0]            w_addr;
    ch_dec_t                w_dec;
    logic                   w_glb_hit;
    logic                   w_hit;
    logic                   w_setup;
    logic                   w_wr;
    logic                   w_ctrl_wr;
    logic                   w_clr_all;
    logic [31:0]            w_rdata;
    logic [CHANNELS-1:0]    w_err_wr;
    logic [CHANNELS-1:0]    w_cnt_clr;
    logic [CHANNELS-1:0]    w_err_buf;
    logic [CHANNELS-1:0]    w_err_pkt;
    logic [COUNT_WIDTH-1:0] w_count [CHANNELS];
    logic [CHANNELS-1:0]    w_irq_status;
    logic                   w_unused;

    logic [31:0]            r_prdata;
    logic                   r_pslverr;
    logic [CHANNELS-1:0]    r_irq_en;
    logic                   r_irq;

    // Byte lanes are ignored; everything decodes on word addresses.
    assign w_addr    = 32'(i_paddr) & ~32'h3;
    assign w_dec     = ch_decode(w_addr, 32'(CHANNELS));
    assign w_glb_hit = (w_addr < CH_BASE);
    assign w_hit     = w_glb_hit | w_dec.hit;

    assign w_setup   = i_psel & ~i_penable;
    assign w_wr      = i_psel & i_penable & i_pwrite & w_hit;
    assign w_ctrl_wr = w_wr & (w_addr == CTRL_OFS);
    assign w_clr_all = w_ctrl_wr & i_pwdata[CNT_CLR_ALL_BIT];

    assign w_irq_status = r_irq_en & (w_err_buf | w_err_pkt);
    assign w_unused     = ^i_pwdata;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic w_ch_wr;

        assign w_ch_wr      = w_wr & w_dec.hit & (w_dec.channel == ch_idx_t'(c));
        assign w_err_wr[c]  = w_ch_wr & (w_dec.sel == REG_ERR);
        assign w_cnt_clr[c] = (w_ch_wr & (w_dec.sel == REG_COUNT)) | w_clr_all;

        status_channel #(
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_channel (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_err_buffer (i_err_buffer[c]),
            .i_err_packet (i_err_packet[c]),
            .i_pkt_done   (i_pkt_done[c]),
            .i_err_wr     (w_err_wr[c]),
            .i_w1c_buf    (i_pwdata[ERR_BUF_BIT]),
            .i_w1c_pkt    (i_pwdata[ERR_PKT_BIT]),
            .i_clr_req    (i_pwdata[ERR_CLR_BIT]),
            .i_cnt_clr    (w_cnt_clr[c]),
            .o_err_buf    (w_err_buf[c]),
            .o_err_pkt    (w_err_pkt[c]),
            .o_count      (w_count[c]),
            .o_err_clear  (o_err_clear[c])
        );
    end

    always_comb begin
        w_rdata = '0;
        if (w_glb_hit) begin
            if (w_addr == CTRL_OFS) begin
                w_rdata[CHANNELS-1:0] = r_irq_en;
            end else if (w_addr == IRQ_OFS) begin
                w_rdata[CHANNELS-1:0] = w_irq_status;
            end
        end else if (w_dec.hit) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_dec.channel == ch_idx_t'(c)) begin
                    case (w_dec.sel)
                        REG_STATUS: begin
                            w_rdata[ID_WIDTH-1:0]          = i_id[c*ID_WIDTH +: ID_WIDTH];
                            w_rdata[ID_WIDTH +: BUF_WIDTH] = i_buffered[c*BUF_WIDTH +: BUF_WIDTH];
                        end
                        REG_ERR: begin
                            w_rdata[ERR_BUF_BIT] = w_err_buf[c];
                            w_rdata[ERR_PKT_BIT] = w_err_pkt[c];
                        end
                        REG_COUNT: w_rdata[COUNT_WIDTH-1:0] = w_count[c];
                        default:   w_rdata = '0;
                    endcase
                end
            end
        end
    end

    // Read data and error are captured at the setup edge and held for the access phase.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_setup) begin
                r_prdata  <= w_rdata;
                r_pslverr <= ~w_hit;
            end
            if (w_ctrl_wr) begin
                r_irq_en <= i_pwdata[CHANNELS-1:0];
            end
            r_irq <= |w_irq_status;
        end
    end

    assign o_prdata  = r_prdata;
    assign o_pslverr = r_pslverr;
    assign o_pready  = 1'b1;
    assign o_irq     = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_status_collector.sv
`default_nettype none
// =============================================================================
// Module   : tb_status_collector
// Desc     : Self-checking bench for status_collector (CHANNELS=4, COUNT_WIDTH=4).
// Revision : 1.0 - initial release
// =============================================================================
module tb_status_collector;

    localparam int CHANNELS    = 4;
    localparam int ID_WIDTH    = 6;
    localparam int BUF_WIDTH   = 3;
    localparam int COUNT_WIDTH = 4;
    localparam int ADDR_WIDTH  = 8;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic                          psel = 1'b0;
    logic                          penable = 1'b0;
    logic                          pwrite = 1'b0;
    logic [ADDR_WIDTH-1:0]         paddr = '0;
    logic [31:0]                   pwdata = '0;
    logic [31:0]                   prdata;
    logic                          pready;
    logic                          pslverr;
    logic [CHANNELS*ID_WIDTH-1:0]  id = '0;
    logic [CHANNELS*BUF_WIDTH-1:0] buffered = '0;
    logic [CHANNELS-1:0]           err_buffer = '0;
    logic [CHANNELS-1:0]           err_packet = '0;
    logic [CHANNELS-1:0]           pkt_done = '0;
    logic [CHANNELS-1:0]           err_clear;
    logic                          irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] rd;
    logic        er;

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs [14];

    status_collector #(
        .CHANNELS    (CHANNELS),
        .ID_WIDTH    (ID_WIDTH),
        .BUF_WIDTH   (BUF_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_psel       (psel),
        .i_penable    (penable),
        .i_pwrite     (pwrite),
        .i_paddr      (paddr),
        .i_pwdata     (pwdata),
        .o_prdata     (prdata),
        .o_pready     (pready),
        .o_pslverr    (pslverr),
        .i_id         (id),
        .i_buffered   (buffered),
        .i_err_buffer (err_buffer),
        .i_err_packet (err_packet),
        .i_pkt_done   (pkt_done),
        .o_err_clear  (err_clear),
        .o_irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One APB transfer; pkt/ep pulses are driven during the access-phase cycle.
    task automatic apb(input logic wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] pkt, input logic [3:0] ep,
                       output logic [31:0] rdata, output logic err);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1; pkt_done = pkt; err_packet = ep;
        rdata = prdata; err = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pkt_done = '0; err_packet = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic        e;
        apb(1'b1, a, d, 4'h0, 4'h0, r, e);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        e;
        apb(1'b0, a, 32'h0, 4'h0, 4'h0, r, e);
        check(name, r, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 32'h0,         1'b1, 32'h0,        1'b0, "rst_ctrl"};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,         1'b1, 32'h0,        1'b0, "rst_irq_status"};
        vecs[2]  = '{1'b0, 8'h14, 32'h0,         1'b1, 32'h0,        1'b0, "rst_err0"};
        vecs[3]  = '{1'b0, 8'h18, 32'h0,         1'b1, 32'h0,        1'b0, "rst_count0"};
        vecs[4]  = '{1'b0, 8'h20, 32'h0,         1'b1, 32'h0000016A, 1'b0, "status1"};
        vecs[5]  = '{1'b0, 8'h23, 32'h0,         1'b1, 32'h0000016A, 1'b0, "status1_bytelane"};
        vecs[6]  = '{1'b0, 8'h10, 32'h0,         1'b1, 32'h0,        1'b0, "status0"};
        vecs[7]  = '{1'b0, 8'h0C, 32'h0,         1'b1, 32'h0,        1'b0, "rsvd_0c"};
        vecs[8]  = '{1'b0, 8'h1C, 32'h0,         1'b1, 32'h0,        1'b0, "rsvd_ch0"};
        vecs[9]  = '{1'b0, 8'hF0, 32'h0,         1'b1, 32'h0,        1'b1, "oom_f0"};
        vecs[10] = '{1'b0, 8'h50, 32'h0,         1'b1, 32'h0,        1'b1, "oom_ch4"};
        vecs[11] = '{1'b1, 8'hF0, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b1, "oom_write"};
        vecs[12] = '{1'b0, 8'h00, 32'h0,         1'b1, 32'h0,        1'b0, "ctrl_after_oom"};
        vecs[13] = '{1'b0, 8'h34, 32'h0,         1'b1, 32'h0,        1'b0, "err2_after_oom"};

        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_prdata",    prdata,    32'h0);
        check("rst_pslverr",   pslverr,   32'h0);
        check("rst_irq",       irq,       32'h0);
        check("rst_err_clear", err_clear, 32'h0);
        check("pready",        pready,    32'h1);

        id[1*ID_WIDTH +: ID_WIDTH]        = 6'h2A;
        buffered[1*BUF_WIDTH +: BUF_WIDTH] = 3'd5;

        for (int i = 0; i < 14; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4'h0, 4'h0, rd, er);
            if (vecs[i].chk_rd) check({vecs[i].name, "_data"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_pslverr"}, er, {31'h0, vecs[i].exp_err});
        end

        // Sticky packet error on channel 2 with interrupt
        @(negedge clk); err_packet[2] = 1'b1;
        @(negedge clk); err_packet = '0;
        wr(8'h00, 32'h4);
        check("irq_not_yet", irq, 32'h0);
        @(negedge clk);
        check("irq_set", irq, 32'h1);
        rd_chk("irq_status", 8'h04, 32'h4);
        rd_chk("err2_set", 8'h34, 32'h2);
        wr(8'h34, 32'h2);
        check("irq_hold_one", irq, 32'h1);
        @(negedge clk);
        check("irq_cleared", irq, 32'h0);
        rd_chk("err2_w1c", 8'h34, 32'h0);

        // Set wins over a coincident W1C
        @(negedge clk); err_packet[2] = 1'b1;
        @(negedge clk); err_packet = '0;
        apb(1'b1, 8'h34, 32'h2, 4'h0, 4'b0100, rd, er);
        rd_chk("err2_set_wins", 8'h34, 32'h2);
        check("irq_still_set", irq, 32'h1);

        // Dropping irq_en deasserts o_irq a cycle later
        wr(8'h00, 32'h0);
        check("irq_en_drop_hold", irq, 32'h1);
        @(negedge clk);
        check("irq_en_drop", irq, 32'h0);
        wr(8'h34, 32'h3);
        rd_chk("err2_final_clear", 8'h34, 32'h0);

        // Error-clear pulse on channel 0 leaves the sticky flag alone
        @(negedge clk); err_buffer[0] = 1'b1;
        @(negedge clk); err_buffer = '0;
        apb(1'b1, 8'h14, 32'h8000_0000, 4'h0, 4'h0, rd, er);
        check("err_clear_pulse", err_clear, 32'h1);
        @(negedge clk);
        check("err_clear_one_cycle", err_clear, 32'h0);
        rd_chk("err0_kept", 8'h14, 32'h1);
        rd_chk("irq_status_masked", 8'h04, 32'h0);
        check("irq_masked", irq, 32'h0);

        // Counter increments and saturates
        @(negedge clk); pkt_done[3] = 1'b1;
        repeat (3) @(negedge clk);
        pkt_done = '0;
        rd_chk("count3_three", 8'h48, 32'h3);
        @(negedge clk); pkt_done[3] = 1'b1;
        repeat (17) @(negedge clk);
        pkt_done = '0;
        rd_chk("count3_saturated", 8'h48, 32'hF);
        apb(1'b1, 8'h48, 32'h0, 4'b1000, 4'h0, rd, er);
        rd_chk("count3_clear_and_inc", 8'h48, 32'h1);
        wr(8'h48, 32'h0);
        rd_chk("count3_write_clear", 8'h48, 32'h0);

        // Clear-all with a coincident packet on channel 0
        @(negedge clk); pkt_done[3] = 1'b1;
        @(negedge clk); pkt_done = 4'b0001;
        @(negedge clk); pkt_done = 4'b0001;
        @(negedge clk); pkt_done = '0;
        rd_chk("count0_two", 8'h18, 32'h2);
        rd_chk("count3_one", 8'h48, 32'h1);
        apb(1'b1, 8'h00, 32'h8000_0004, 4'b0001, 4'h0, rd, er);
        rd_chk("ctrl_readback", 8'h00, 32'h4);
        rd_chk("count3_clear_all", 8'h48, 32'h0);
        rd_chk("count0_clear_all_inc", 8'h18, 32'h1);

        // Reset in the middle of a write aborts it
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'h0000_000F;
        @(negedge clk);
        penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("midrst_prdata",  prdata,  32'h0);
        check("midrst_pslverr", pslverr, 32'h0);
        check("midrst_irq",     irq,     32'h0);
        rd_chk("midrst_ctrl",   8'h00, 32'h0);
        rd_chk("midrst_err0",   8'h14, 32'h0);
        rd_chk("midrst_count0", 8'h18, 32'h0);
        wr(8'h00, 32'h1);
        rd_chk("post_abort_ctrl", 8'h00, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
